seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler for 7-segment displays. NDIG digit patterns (e.g. seg0/seg1 from segcnt) share one physical segment bus.
The block drives each digit in turn through a one-hot digit select. A blanking gap sits between digits to prevent ghosting.
It sits between the counter/decoder datapath and the board pins.

Parameters:
NDIG, 2, number of digits sharing the segment bus (2..8)
SHOW_CYC, 1000, clk cycles a digit is driven per slot (>=1)
BLANK_CYC, 16, clk cycles of all-off gap before each digit (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; low = display dark, scan restarts at digit 0
seg_in  input  7*NDIG  digit patterns; digit k at bits [7k+6:7k], bit0=a..bit6=g, 1=lit
mask  input  NDIG  1 = suppress digit k (its slot still elapses, dark)
seg_out  output  7  segment bus, 1=lit
dig_sel  output  NDIG  one-hot digit enable, 1=on; all-zero when dark
frame_tick  output  1  one-cycle pulse at end of digit NDIG-1's SHOW slot

Behaviour:
- All outputs registered. Reset (async, immediate) values:
  - seg_out=0, dig_sel=0, frame_tick=0.
  - Internal: state=IDLE, idx=0, timer=0.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs dark, idx=0.
  - en=1 at an edge -> BLANK, timer loaded BLANK_CYC-1.
- BLANK:
  - seg_out=0, dig_sel=0.
  - Timer counts down; at 0 -> SHOW, timer loaded SHOW_CYC-1.
  - On that same edge, latch seg_in slice idx into the seg_out register.
  - BLANK duration is exactly BLANK_CYC cycles.
- SHOW:
  - seg_out holds the latched pattern; later seg_in changes are ignored until the next slot (no tearing).
  - dig_sel = one-hot(idx) if mask[idx]==0, else 0.
  - seg_out is forced to 0 when masked.
  - Duration exactly SHOW_CYC cycles.
  - At timer 0 -> BLANK, idx = (idx==NDIG-1) ? 0 : idx+1.
  - frame_tick=1 for the cycle following that edge, only when wrapping from NDIG-1.
- Slot period = BLANK_CYC+SHOW_CYC; frame period = NDIG*(BLANK_CYC+SHOW_CYC).
- Duty per digit is constant regardless of mask.
- en falls in any state: next edge -> IDLE, seg_out=0, dig_sel=0, idx=0, frame_tick=0.
- en high again: restarts with BLANK of digit 0.
- mask changes mid-SHOW: take effect on the next cycle (dig_sel/seg_out registered from current mask). No glitch beyond one-cycle granularity.
- Invariant: dig_sel is never multi-hot. dig_sel!=0 only in SHOW.
- Timer width = $clog2(max(SHOW_CYC,BLANK_CYC)+1); idx width = $clog2(NDIG), minimum 1.
- Reset asserted mid-SHOW: outputs dark asynchronously. After release, IDLE; scan begins on the first edge with en=1.

Decomposition:
- Shared package seg_pkg:
  - state enum (IDLE/BLANK/SHOW)
  - SEG_OFF=7'h00
  - segment bit-order constants (SEG_A..SEG_G)
- One natural sub-module: slot_timer.
  - Loadable down-counter with load value input and done flag at 0.
  - Instantiated once; the FSM reloads it per state.

Test Plan:
Bench uses NDIG=2, SHOW_CYC=4, BLANK_CYC=2, seg_in={7'h06,7'h3F} (digit1="1", digit0="0"), mask=0.
- Reset/idle: rst=1 then 0, en=0 for 20 cycles -> seg_out=0, dig_sel=0, frame_tick=0 throughout.
- Scan order: raise en -> 2 dark cycles, then 4 cycles dig_sel=01/seg_out=3F, then 2 dark, then 4 cycles dig_sel=10/seg_out=06. frame_tick pulses once per 12 cycles, in the cycle after digit-1 SHOW ends. Repeat 3 frames.
- Latch stability: change seg_in[6:0] to 7'h5B in the 2nd cycle of digit-0 SHOW -> seg_out stays 3F to slot end; next frame shows 5B.
- Mask: mask=2'b10 -> digit-1 slot has dig_sel=0, seg_out=0 for 4 cycles. frame_tick period is still 12.
- en drop mid-slot: en=0 in cycle 3 of digit-1 SHOW -> next edge dark, idx=0. en=1 later -> restarts with digit-0 BLANK.
- Async reset: assert rst between edges during SHOW -> outputs 0 before the next clk edge. Check no multi-hot dig_sel over 1000 random en/mask cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan controller.
//   state_t       : scan FSM states (IDLE / BLANK / SHOW)
//   SEG_OFF       : all segments dark
//   SEG_A..SEG_G  : bit positions of each segment inside a 7-bit pattern
//   max_int()     : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// -----------------------------------------------------------------------------
// slot_timer
// Loadable down-counter that times the BLANK and SHOW slots.
//   clk        : system clock
//   rst        : asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val on the next edge (has priority)
//   i_load_val : value to load
//   o_done     : count is zero; the current slot ends at the next edge
// -----------------------------------------------------------------------------
module slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes NDIG 7-segment patterns onto one segment bus. Each digit
// slot is BLANK_CYC dark cycles followed by SHOW_CYC cycles with the digit
// driven. The pattern is captured at the start of SHOW so it cannot tear.
//   clk        : system clock
//   rst        : asynchronous active-high reset, outputs go dark at once
//   en         : scan enable; low = dark, scan restarts at digit 0
//   seg_in     : NDIG patterns, digit k at [7k+6:7k], bit0=a .. bit6=g
//   mask       : 1 = keep digit k dark (its slot still elapses)
//   seg_out    : registered segment bus, 1 = lit
//   dig_sel    : registered one-hot digit enable, all-zero when dark
//   frame_tick : one-cycle pulse after the last digit's SHOW slot ends
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 2,
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7*NDIG-1:0] seg_in,
  input  logic [NDIG-1:0]   mask,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame_tick
);

  localparam int TMR_W = $clog2(max_int(SHOW_CYC, BLANK_CYC) + 1);
  localparam int IDX_W = (NDIG > 2) ? $clog2(NDIG) : 1;

  localparam logic [TMR_W-1:0] LD_BLANK = TMR_W'(BLANK_CYC - 1);
  localparam logic [TMR_W-1:0] LD_SHOW  = TMR_W'(SHOW_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [6:0]       r_pat, w_pat_nxt;
  logic [6:0]       r_seg, w_seg_nxt;
  logic [NDIG-1:0]  r_dig, w_dig_nxt;
  logic             r_tick, w_tick_nxt;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_done;

  logic [6:0]       w_digits [NDIG];
  logic [6:0]       w_slice;
  logic             w_masked;
  logic [NDIG-1:0]  w_onehot;

  for (genvar k = 0; k < NDIG; k++) begin : g_split
    assign w_digits[k] = seg_in[7*k +: 7];
  end

  assign w_slice  = w_digits[r_idx];
  assign w_masked = mask[r_idx];
  assign w_onehot = NDIG'(1) << r_idx;

  slot_timer #(
    .W (TMR_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pat   <= SEG_OFF;
      r_seg   <= SEG_OFF;
      r_dig   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pat   <= w_pat_nxt;
      r_seg   <= w_seg_nxt;
      r_dig   <= w_dig_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Outputs are computed for the cycle after the edge, so mask changes show
  // up one cycle later and the first SHOW cycle already carries the pattern.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_seg_nxt   = SEG_OFF;
    w_dig_nxt   = '0;
    w_tick_nxt  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;

    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_tmr_load  = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_tmr_load  = 1'b1;
          w_tmr_val   = LD_BLANK;
        end
        ST_BLANK: begin
          if (w_tmr_done) begin
            w_state_nxt = ST_SHOW;
            w_tmr_load  = 1'b1;
            w_tmr_val   = LD_SHOW;
            w_pat_nxt   = w_slice;
            if (!w_masked) begin
              w_seg_nxt = w_slice;
              w_dig_nxt = w_onehot;
            end
          end
        end
        ST_SHOW: begin
          if (w_tmr_done) begin
            w_state_nxt = ST_BLANK;
            w_tmr_load  = 1'b1;
            w_tmr_val   = LD_BLANK;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            w_tick_nxt  = (r_idx == IDX_LAST);
          end else if (!w_masked) begin
            w_seg_nxt = r_pat;
            w_dig_nxt = w_onehot;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  assign seg_out    = r_seg;
  assign dig_sel    = r_dig;
  assign frame_tick = r_tick;

endmodule
